run_monitor: RTL and testbench

RUN_MONITOR -- requirements
Module: run_monitor

---
 rtl/run_monitor.sv | 153 +++++++++++++++
 tb/tb_run_monitor.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/run_monitor.sv
// run_monitor: watches a processor run, logs data-memory writes with their
// capture cycle into a show-ahead FIFO, and tracks run/drain/done/timeout.
module run_monitor #(
   parameter int         ADDR_W       = 32,
   parameter int         DATA_W       = 32,
   parameter int         DEPTH        = 16,
   parameter int         CYC_W        = 32,
   parameter logic [5:0] HALT_OPCODE  = 6'h11,
   parameter int         DRAIN_CYCLES = 4,
   parameter int         TIMEOUT      = 100000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [5:0]        opcode,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_din,
   input  logic              rd_en,
   output logic              rd_valid,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic [CYC_W-1:0]  rd_cycle,
   output logic [CYC_W-1:0]  cycle,
   output logic [1:0]        state,
   output logic              done,
   output logic              timed_out,
   output logic              overflow,
   output logic [15:0]       dropped
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_DONE    = 2'd2,
      ST_TIMEOUT = 2'd3
   } state_t;

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'(DRAIN_CYCLES - 1);
   localparam logic [CYC_W-1:0]  CYC_LAST   = CYC_W'(TIMEOUT - 1);

   state_t              r_state;
   logic [CYC_W-1:0]    r_cycle;
   logic [DCNT_W-1:0]   r_drainCnt;

   logic [ADDR_W-1:0]   r_memAddr  [DEPTH];
   logic [DATA_W-1:0]   r_memData  [DEPTH];
   logic [CYC_W-1:0]    r_memCycle [DEPTH];
   logic [PTR_W:0]      r_wrPtr;
   logic [PTR_W:0]      r_rdPtr;
   logic                r_overflow;
   logic [15:0]         r_dropped;

   logic w_active;
   logic w_timeUp;
   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_pushReq;
   logic w_push;
   logic w_drop;

   // The limit test uses >= so a run that halts on the last RUN cycle still
   // times out one cycle later, when the counter has already moved past it.
   assign w_active  = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   assign w_timeUp  = (r_cycle >= CYC_LAST);
   assign w_empty   = (r_wrPtr == r_rdPtr);
   assign w_full    = (r_wrPtr[PTR_W] != r_rdPtr[PTR_W]) &&
                      (r_wrPtr[PTR_W-1:0] == r_rdPtr[PTR_W-1:0]);
   assign w_pop     = rd_en && !w_empty;
   assign w_pushReq = mem_we && w_active;
   assign w_push    = w_pushReq && (!w_full || w_pop);
   assign w_drop    = w_pushReq && w_full && !w_pop;

   // Run-state machine and cycle counter; a halt beats the time limit in RUN,
   // while the time limit beats any remaining drain in DRAIN.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_RUN;
         r_cycle    <= '0;
         r_drainCnt <= '0;
      end else begin
         case (r_state)
            ST_RUN: begin
               r_cycle <= r_cycle + 1'b1;
               if (opcode == HALT_OPCODE) begin
                  r_state    <= ST_DRAIN;
                  r_drainCnt <= DRAIN_LOAD;
               end else if (w_timeUp) begin
                  r_state <= ST_TIMEOUT;
               end
            end
            ST_DRAIN: begin
               r_cycle <= r_cycle + 1'b1;
               if (w_timeUp) begin
                  r_state <= ST_TIMEOUT;
               end else if (r_drainCnt == '0) begin
                  r_state <= ST_DONE;
               end else begin
                  r_drainCnt <= r_drainCnt - 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Log storage; only the pointers need resetting, stale slots are unreachable.
   always_ff @(posedge clk) begin
      if (w_push && !reset) begin
         r_memAddr[r_wrPtr[PTR_W-1:0]]  <= mem_addr;
         r_memData[r_wrPtr[PTR_W-1:0]]  <= mem_din;
         r_memCycle[r_wrPtr[PTR_W-1:0]] <= r_cycle;
      end
   end

   // FIFO pointers plus the sticky overflow flag and saturating drop count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wrPtr    <= '0;
         r_rdPtr    <= '0;
         r_overflow <= 1'b0;
         r_dropped  <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_dropped != 16'hFFFF) begin
               r_dropped <= r_dropped + 16'd1;
            end
         end
      end
   end

   assign rd_valid  = !w_empty;
   assign rd_addr   = r_memAddr[r_rdPtr[PTR_W-1:0]];
   assign rd_data   = r_memData[r_rdPtr[PTR_W-1:0]];
   assign rd_cycle  = r_memCycle[r_rdPtr[PTR_W-1:0]];
   assign cycle     = r_cycle;
   assign state     = r_state;
   assign done      = (r_state == ST_DONE);
   assign timed_out = (r_state == ST_TIMEOUT);
   assign overflow  = r_overflow;
   assign dropped   = r_dropped;

endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor: randomized episodes against a run-window reference model,
// with a decoupled scoreboard monitor comparing status and popped log entries.
module tb_run_monitor;

   localparam int         ADDR_W  = 16;
   localparam int         DATA_W  = 16;
   localparam int         DEPTH   = 4;
   localparam int         CYC_W   = 16;
   localparam logic [5:0] HALT    = 6'h11;
   localparam int         DRAIN   = 4;
   localparam int         TIMEOUT = 20;

   logic              clk;
   logic              reset;
   logic [5:0]        opcode;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din;
   logic              rd_en;
   logic              rd_valid;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic [CYC_W-1:0]  rd_cycle;
   logic [CYC_W-1:0]  cycle;
   logic [1:0]        state;
   logic              done;
   logic              timed_out;
   logic              overflow;
   logic [15:0]       dropped;

   typedef struct {
      int st;
      int cyc;
      int valid;
      int ovf;
      int drp;
   } status_t;

   typedef struct {
      int addr;
      int data;
      int cyc;
   } entry_t;

   status_t stQueue[$];
   entry_t  sbQueue[$];

   int vectors;
   int miscompares;

   int mCycle;
   int mHaltAt;
   int mOcc;
   int mOverflow;
   int mDropped;

   run_monitor #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CYC_W(CYC_W),
      .HALT_OPCODE(HALT), .DRAIN_CYCLES(DRAIN), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_din(mem_din), .rd_en(rd_en),
      .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_cycle(rd_cycle), .cycle(cycle), .state(state), .done(done),
      .timed_out(timed_out), .overflow(overflow), .dropped(dropped)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Run outcome from the halt cycle and the time limit: 0 RUN, 1 DRAIN,
   // 2 DONE, 3 TIMEOUT. A run is active up to the last cycle it may log.
   function automatic int modelState();
      int lastActive;
      int limit;
      if (mHaltAt < 0) return (mCycle <= TIMEOUT - 1) ? 0 : 3;
      limit      = (TIMEOUT - 1 > mHaltAt + 1) ? TIMEOUT - 1 : mHaltAt + 1;
      lastActive = (mHaltAt + DRAIN < limit) ? mHaltAt + DRAIN : limit;
      if (mCycle <= lastActive) return 1;
      return (mHaltAt + DRAIN < TIMEOUT - 1) ? 2 : 3;
   endfunction

   function automatic void modelReset();
      mCycle    = 0;
      mHaltAt   = -1;
      mOcc      = 0;
      mOverflow = 0;
      mDropped  = 0;
   endfunction

   function automatic status_t resetStatus();
      status_t s;
      s.st = 0; s.cyc = 0; s.valid = 0; s.ovf = 0; s.drp = 0;
      return s;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      vectors++;
      if (actual != expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic logic [5:0] nonHaltOpcode();
      logic [5:0] o;
      o = 6'($urandom_range(0, 63));
      if (o == HALT) o = o ^ 6'h01;
      return o;
   endfunction

   // One clock of stimulus: record expected status, drive inputs, advance model.
   task automatic applyStimulus(input int forceHaltAt, input int readPct, input int writePct);
      status_t s;
      entry_t  e;
      int      st;
      bit      active;
      bit      pop;
      bit      push;
      reset = 1'b0;
      st = modelState();
      s.st = st; s.cyc = mCycle; s.valid = (mOcc > 0) ? 1 : 0;
      s.ovf = mOverflow; s.drp = mDropped;
      stQueue.push_back(s);

      mem_we   = ($urandom_range(0, 99) < writePct);
      mem_addr = ADDR_W'($urandom);
      mem_din  = DATA_W'($urandom);
      rd_en    = ($urandom_range(0, 99) < readPct);
      if (forceHaltAt == -2)
         opcode = ($urandom_range(0, 15) == 0) ? HALT : nonHaltOpcode();
      else if ((st == 0 && mCycle == forceHaltAt) || (st >= 2 && $urandom_range(0, 3) == 0))
         opcode = HALT;
      else
         opcode = nonHaltOpcode();

      active = (st == 0 || st == 1);
      pop    = rd_en && (mOcc > 0);
      push   = mem_we && active;
      if (push) begin
         if (mOcc == DEPTH && !pop) begin
            mOverflow = 1;
            if (mDropped < 16'hFFFF) mDropped++;
         end else begin
            e.addr = int'(mem_addr); e.data = int'(mem_din); e.cyc = mCycle;
            sbQueue.push_back(e);
            mOcc++;
         end
      end
      if (pop) mOcc--;
      if (st == 0 && opcode == HALT) mHaltAt = mCycle;
      if (active) mCycle++;
   endtask

   // Reset raised between clock edges; the next negedge must already see it.
   task automatic resetBetweenEdges();
      @(posedge clk);
      #3;
      reset = 1'b1;
      stQueue.delete();
      sbQueue.delete();
      modelReset();
      stQueue.push_back(resetStatus());
      @(posedge clk);
      #1;
      stQueue.push_back(resetStatus());
   endtask

   // Monitor: compares the status expected for each cycle, and the head entry
   // whenever the DUT offers one that is being popped.
   initial begin
      status_t s;
      entry_t  e;
      forever begin
         @(negedge clk);
         if (stQueue.size() > 0) begin
            s = stQueue.pop_front();
            checkOutput("state",     int'(state),     s.st);
            checkOutput("cycle",     int'(cycle),     s.cyc);
            checkOutput("rd_valid",  int'(rd_valid),  s.valid);
            checkOutput("done",      int'(done),      (s.st == 2) ? 1 : 0);
            checkOutput("timed_out", int'(timed_out), (s.st == 3) ? 1 : 0);
            checkOutput("overflow",  int'(overflow),  s.ovf);
            checkOutput("dropped",   int'(dropped),   s.drp);
         end
         if (!reset && rd_valid && rd_en) begin
            if (sbQueue.size() == 0) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL pop_empty: got rd_valid 1 expected no entry at %0t", $time);
            end else begin
               e = sbQueue.pop_front();
               checkOutput("rd_addr",  int'(rd_addr),  e.addr);
               checkOutput("rd_data",  int'(rd_data),  e.data);
               checkOutput("rd_cycle", int'(rd_cycle), e.cyc);
            end
         end
      end
   end

   // Episodes cycle through halt points around the drain/timeout boundaries.
   initial begin
      int haltAt;
      int readPct;
      int writePct;
      int len;
      int kind;
      vectors     = 0;
      miscompares = 0;
      reset    = 1'b1;
      opcode   = '0;
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_din  = '0;
      rd_en    = 1'b0;
      modelReset();
      @(posedge clk);
      #1;
      stQueue.push_back(resetStatus());

      for (int ep = 0; ep < 48; ep++) begin
         kind = ep % 6;
         case (kind)
            0: haltAt = 7;
            1: haltAt = TIMEOUT - 1;
            2: haltAt = TIMEOUT - 1 - DRAIN;
            3: haltAt = TIMEOUT - 2 - DRAIN;
            4: haltAt = -1;
            default: haltAt = -2;
         endcase
         len      = 28;
         readPct  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(10, 60);
         writePct = $urandom_range(30, 90);
         if (kind == 0 && ((ep / 6) % 2) == 1) begin
            len      = 10;
            readPct  = 0;
            writePct = 70;
         end
         for (int k = 0; k < len; k++) begin
            @(posedge clk);
            #1;
            applyStimulus(haltAt, readPct, writePct);
         end
         resetBetweenEdges();
      end

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
